// File: rtl/gmii2fifo72_pkg.sv
// gmii2fifo72_pkg: 72-bit FIFO word format and packer state encoding shared with fifo72togmii
package gmii2fifo72_pkg;
  localparam int FIFO72_W = 72;
  localparam int MASK_MSB = 71;
  localparam int MASK_LSB = 64;
  localparam logic [FIFO72_W-1:0] DELIM_WORD = '0;
  typedef enum logic [1:0] {IDLE, RECV, DROP, FLUSH} state_t;
  function automatic logic [5:0] lane_lsb(input logic [2:0] k);
    return {3'd7 - k, 3'd0};
  endfunction
endpackage

// File: rtl/gmii2fifo72_if.sv
// gmii2fifo72_if: GMII receive pins plus FIFO write port of the packer
interface gmii2fifo72_if;
  logic gmii_rx_dv;
  logic gmii_rx_er;
  logic [7:0] gmii_rxd;
  logic full;
  logic wr_en;
  logic [gmii2fifo72_pkg::FIFO72_W-1:0] din;
  modport master (input gmii_rx_dv, gmii_rx_er, gmii_rxd, full, output din, wr_en);
  modport slave (output gmii_rx_dv, gmii_rx_er, gmii_rxd, full, input din, wr_en);
endinterface

// File: rtl/gmii2fifo72_pack.sv
// gmii2fifo72_pack: lane index plus byte/mask shift register; lane 7 push or clr empties it
module gmii2fifo72_pack import gmii2fifo72_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic clr,
  input  logic [7:0] rx_byte,
  output logic [2:0] idx,
  output logic [FIFO72_W-1:0] cur,
  output logic [FIFO72_W-1:0] merged
);
  logic [63:0] data_q, data_m;
  logic [MASK_MSB-MASK_LSB:0] mask_q, mask_m;
  always_comb begin
    data_m = data_q;
    mask_m = mask_q;
    data_m[lane_lsb(idx) +: 8] = rx_byte;
    mask_m[3'd7 - idx] = 1'b1;
  end
  assign cur = {mask_q, data_q};
  assign merged = {mask_m, data_m};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mask_q <= '0;
      idx <= '0;
    end else if (clr || (push && idx == 3'd7)) begin
      data_q <= '0;
      mask_q <= '0;
      idx <= '0;
    end else if (push) begin
      data_q <= data_m;
      mask_q <= mask_m;
      idx <= idx + 3'd1;
    end
  end
endmodule

// File: rtl/gmii2fifo72.sv
// gmii2fifo72: GMII RX byte stream packed into 72-bit FIFO words with frame delimiters and saturating stats
module gmii2fifo72 import gmii2fifo72_pkg::*; #(
  parameter int CNT_WIDTH = 16
) (
  input  logic gmii_rx_clk,
  input  logic sys_rst_n,
  gmii2fifo72_if.master rx,
  output logic wr_clk,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);
  logic s1_dv, s1_er, prev_dv;
  logic [7:0] s1_d;
  state_t state, state_n;
  logic dpend, dpend_n;
  logic push, clr, wr_n, wr_q;
  logic inc_frame, inc_err, inc_drop;
  logic [2:0] idx;
  logic [FIFO72_W-1:0] cur, merged, din_n, din_q;
  gmii2fifo72_pack u_pack (
    .clk(gmii_rx_clk), .rst_n(sys_rst_n), .push(push), .clr(clr),
    .rx_byte(s1_d), .idx(idx), .cur(cur), .merged(merged)
  );
  assign wr_clk = gmii_rx_clk;
  assign rx.din = din_q;
  assign rx.wr_en = wr_q;
  always_comb begin
    state_n = state;
    dpend_n = dpend;
    push = 1'b0;
    clr = 1'b0;
    wr_n = 1'b0;
    din_n = din_q;
    inc_frame = 1'b0;
    inc_err = 1'b0;
    inc_drop = 1'b0;
    case (state)
      IDLE: begin
        push = s1_dv;
        state_n = s1_dv ? RECV : IDLE;
      end
      RECV: begin
        if (s1_dv && s1_er) begin
          clr = 1'b1;
          inc_err = 1'b1;
          dpend_n = 1'b1;
          state_n = FLUSH;
        end else if (s1_dv) begin
          push = 1'b1;
          if (idx == 3'd7 && rx.full) begin
            clr = 1'b1;
            inc_drop = 1'b1;
            state_n = DROP;
          end else if (idx == 3'd7) begin
            wr_n = 1'b1;
            din_n = merged;
          end
        end else begin
          clr = 1'b1;
          if (rx.full) begin
            inc_drop = 1'b1;
            dpend_n = 1'b1;
            state_n = FLUSH;
          end else begin
            wr_n = 1'b1;
            din_n = cur;
            inc_frame = 1'b1;
            state_n = IDLE;
          end
        end
      end
      DROP: begin
        dpend_n = !s1_dv;
        state_n = s1_dv ? DROP : FLUSH;
      end
      FLUSH: begin
        if (dpend && !rx.full) begin
          wr_n = 1'b1;
          din_n = DELIM_WORD;
          dpend_n = 1'b0;
        end
        inc_drop = s1_dv && !prev_dv;
        state_n = (!s1_dv && (!dpend || !rx.full)) ? IDLE : FLUSH;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge gmii_rx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1_dv <= 1'b0;
      s1_er <= 1'b0;
      s1_d <= '0;
      prev_dv <= 1'b0;
      state <= IDLE;
      dpend <= 1'b0;
      wr_q <= 1'b0;
      din_q <= '0;
      frame_cnt <= '0;
      err_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      s1_dv <= rx.gmii_rx_dv;
      s1_er <= rx.gmii_rx_er;
      s1_d <= rx.gmii_rxd;
      prev_dv <= s1_dv;
      state <= state_n;
      dpend <= dpend_n;
      wr_q <= wr_n;
      din_q <= din_n;
      frame_cnt <= frame_cnt + CNT_WIDTH'(inc_frame && frame_cnt != '1);
      err_cnt <= err_cnt + CNT_WIDTH'(inc_err && err_cnt != '1);
      drop_cnt <= drop_cnt + CNT_WIDTH'(inc_drop && drop_cnt != '1);
    end
  end
endmodule

// File: tb/tb_gmii2fifo72.sv
// tb_gmii2fifo72: directed GMII frames with a queue scoreboard checked by an independent write monitor
module tb_gmii2fifo72;
  localparam int CW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_clk;
  logic [CW-1:0] frame_cnt, err_cnt, drop_cnt;
  logic [71:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  gmii2fifo72_if rx();
  gmii2fifo72 #(.CNT_WIDTH(CW)) dut (
    .gmii_rx_clk(clk), .sys_rst_n(rst_n), .rx(rx.master), .wr_clk(wr_clk),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );
  always #4 clk = ~clk;
  function automatic logic [7:0] pat(input int i);
    return i < 7 ? 8'h55 : i == 7 ? 8'hD5 : 8'(i * 7 + 3);
  endfunction
  function automatic logic [71:0] mk_word(input int first, input int n);
    logic [63:0] d = '0;
    logic [7:0] m = '0;
    for (int k = 0; k < 8; k++) begin
      d = {d[55:0], (k < n) ? pat(first + k) : 8'h00};
      m = {m[6:0], k < n};
    end
    return {m, d};
  endfunction
  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask
  task automatic idle_pins();
    rx.gmii_rx_dv = 1'b0;
    rx.gmii_rx_er = 1'b0;
    rx.gmii_rxd = 8'h00;
    rx.full = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_pins();
    repeat (3) @(negedge clk);
    chk("rst wr_en", int'(rx.wr_en), 0);
    chk("rst din_zero", int'(rx.din == '0), 1);
    chk("rst counters", int'(frame_cnt) + int'(err_cnt) + int'(drop_cnt), 0);
    rst_n = 1'b1;
  endtask
  task automatic send(input int len, input int er_at, input int f_lo, input int f_hi);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      rx.gmii_rx_dv = 1'b1;
      rx.gmii_rxd = pat(i);
      rx.gmii_rx_er = (i + 1 == er_at);
      rx.full = (i + 1 >= f_lo && i + 1 <= f_hi);
    end
    @(negedge clk);
    idle_pins();
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({nm, " outstanding"}, exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic counts(input string nm, input int f, input int e, input int d);
    chk({nm, " frame_cnt"}, int'(frame_cnt), f);
    chk({nm, " err_cnt"}, int'(err_cnt), e);
    chk({nm, " drop_cnt"}, int'(drop_cnt), d);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (rx.wr_en) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_word: unexpected write din=%h", rx.din);
      end else begin
        logic [71:0] e;
        e = exp_q.pop_front();
        if (rx.din !== e || rx.full !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_word: got din=%h full=%b, required din=%h full=0", rx.din, rx.full, e);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    idle_pins();
    do_reset();
    #1;
    chk("wr_clk follows clk", int'(wr_clk == clk), 1);
    exp_q.push_back(72'hFF_55555555555555D5);
    for (int w = 1; w < 7; w++) exp_q.push_back(mk_word(8 * w, 8));
    exp_q.push_back(mk_word(56, 4));
    send(60, 0, 0, -1);
    drain("t1");
    counts("t1", 1, 0, 0);
    do_reset();
    for (int w = 0; w < 8; w++) exp_q.push_back(mk_word(8 * w, 8));
    exp_q.push_back(72'h00_0000000000000000);
    send(64, 0, 0, -1);
    drain("t2");
    counts("t2", 1, 0, 0);
    do_reset();
    exp_q.push_back(mk_word(0, 8));
    exp_q.push_back(mk_word(8, 8));
    exp_q.push_back(72'h0);
    send(64, 20, 0, -1);
    drain("t3");
    counts("t3", 0, 1, 0);
    do_reset();
    exp_q.push_back(mk_word(0, 8));
    exp_q.push_back(72'h0);
    send(64, 0, 11, 40);
    drain("t4");
    counts("t4", 0, 0, 1);
    do_reset();
    for (int f = 0; f < 2; f++) begin
      exp_q.push_back(mk_word(0, 8));
      exp_q.push_back(72'h80_0000000000000000 | mk_word(8, 1));
    end
    send(9, 0, 0, -1);
    send(9, 0, 0, -1);
    drain("t5");
    counts("t5", 2, 0, 0);
    do_reset();
    exp_q.push_back(mk_word(0, 8));
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      rx.gmii_rx_dv = 1'b1;
      rx.gmii_rxd = pat(i);
    end
    do_reset();
    chk("t6 queue after reset", exp_q.size(), 0);
    exp_q.push_back(mk_word(0, 8));
    exp_q.push_back(72'h0);
    send(8, 0, 0, -1);
    drain("t6");
    counts("t6", 1, 0, 0);
    do_reset();
    for (int f = 0; f < 5; f++) exp_q.push_back(mk_word(0, 3));
    for (int f = 0; f < 5; f++) send(3, 0, 0, -1);
    drain("t7");
    counts("t7 saturate", 3, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
